// File: rtl/regfile_access_arbiter_pkg.sv
// regfile_access_arbiter_pkg: shared encodings and default widths for the register file access arbiter
package regfile_access_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
  localparam int DEF_ADDR_W = 1;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first requester at or above the round-robin pointer, returning one-hot and encoded winner
module rr_arbiter #(
  parameter int N = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx = IDX_W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin sharing of the register file write port and read port 1, with a CLEAR sequence
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic [ADDR_W-1:0]         rf_read_register1,
  input  logic [DATA_W-1:0]         rf_read_data1,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_register,
  output logic [DATA_W-1:0]         rf_write_data
);
  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = ADDR_W + 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_q, rr_d, idx;
  logic pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d, g_addr;
  logic [DATA_W-1:0] pend_data_q, pend_data_d, g_data, fwd;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, gnt;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic any, hit, g_wr;
  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req(req_valid), .ptr(rr_q), .gnt(gnt), .idx(idx), .any(any)
  );
  always_comb begin
    hit = state_q == ST_IDLE && !clear_req && any;
    g_addr = req_addr[int'(idx)*ADDR_W +: ADDR_W];
    g_data = req_wdata[int'(idx)*DATA_W +: DATA_W];
    g_wr = op_e'(req_write[idx]) == OP_WRITE;
    // a write still in the buffer is newer than the register file contents
    fwd = (pend_valid_q && pend_addr_q == g_addr) ? pend_data_q : rf_read_data1;
    req_ready = hit ? gnt : '0;
    rf_read_register1 = (hit && !g_wr) ? g_addr : '0;
    state_d = state_q;
    cnt_d = cnt_q;
    pend_valid_d = 1'b0;
    pend_addr_d = '0;
    pend_data_d = '0;
    if (state_q == ST_CLEAR) begin
      pend_valid_d = 1'b1;
      pend_addr_d = cnt_q[ADDR_W-1:0];
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_d == CNT_W'(1 << ADDR_W)) ? ST_IDLE : ST_CLEAR;
    end else if (clear_req) begin
      state_d = ST_CLEAR;
      cnt_d = '0;
    end else if (hit && g_wr) begin
      pend_valid_d = 1'b1;
      pend_addr_d = g_addr;
      pend_data_d = g_data;
    end
    rr_d = hit ? ((idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1) : rr_q;
    rsp_valid_d = hit ? gnt : '0;
    rsp_rdata_d = (hit && !g_wr) ? fwd : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      rr_q <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign clear_busy = state_q == ST_CLEAR;
  assign rf_write_enable = pend_valid_q;
  assign rf_write_register = pend_addr_q;
  assign rf_write_data = pend_data_q;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: directed vectors with hand-computed expectations against a small register file model
module tb_regfile_access_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_ready, req_write, rsp_valid, req_addr;
  logic [15:0] req_wdata;
  logic [7:0] rsp_rdata, rf_read_data1, rf_write_data;
  logic clear_req, clear_busy, rf_write_enable;
  logic [0:0] rf_read_register1, rf_write_register;
  logic [7:0] rf_m [2];
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  regfile_access_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .rf_read_register1(rf_read_register1), .rf_read_data1(rf_read_data1),
    .rf_write_enable(rf_write_enable), .rf_write_register(rf_write_register),
    .rf_write_data(rf_write_data)
  );
  initial begin
    rf_m[0] = 8'h00;
    rf_m[1] = 8'h00;
  end
  always @(posedge clock) if (rf_write_enable) rf_m[rf_write_register] <= rf_write_data;
  assign rf_read_data1 = rf_m[rf_read_register1];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    clear_req = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    #1 chk("t1_busy_before", 32'(clear_busy), 1);
    reset = 1'b1;
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("t1_busy", 32'(clear_busy), 0);
    chk("t1_we", 32'(rf_write_enable), 0);
    chk("t1_wreg_wdata", {23'd0, rf_write_register, rf_write_data}, 0);
    chk("t1_rsp", {22'd0, rsp_valid, rsp_rdata}, 0);
    cyc();
    chk("t1_busy_after", 32'(clear_busy), 0);
    chk("t1_we_after", 32'(rf_write_enable), 0);
    // test 2: write then forwarded read
    req_valid = 2'b01; req_write = 2'b01; req_addr = 2'b01; req_wdata = 16'h00A5;
    #1 chk("t2_rdy_w", 32'(req_ready), 32'h1);
    cyc();
    req_write = 2'b00;
    #1;
    chk("t2_rdy_r", 32'(req_ready), 32'h1);
    chk("t2_we", {23'd0, rf_write_enable, rf_write_register, rf_write_data}, 32'h3A5);
    chk("t2_rsp_w", {22'd0, rsp_valid, rsp_rdata}, 32'h100);
    chk("t2_rreg", 32'(rf_read_register1), 1);
    cyc();
    req_valid = 2'b10; req_addr = 2'b00;
    #1;
    chk("t2_rsp_r", {22'd0, rsp_valid, rsp_rdata}, 32'h1A5);
    chk("t2_rdy1", 32'(req_ready), 32'h2);
    // test 3: both reading every cycle, rr now 0
    cyc();
    req_valid = 2'b11; req_addr = 2'b10;
    #1 chk("t3_rdy0", 32'(req_ready), 32'h1);
    cyc();
    chk("t3_rdy1", 32'(req_ready), 32'h2);
    chk("t3_rsp0", {22'd0, rsp_valid, rsp_rdata}, 32'h100);
    cyc();
    chk("t3_rdy2", 32'(req_ready), 32'h1);
    chk("t3_rsp1", {22'd0, rsp_valid, rsp_rdata}, 32'h2A5);
    cyc();
    chk("t3_rdy3", 32'(req_ready), 32'h2);
    chk("t3_rsp2", {22'd0, rsp_valid, rsp_rdata}, 32'h100);
    // test 4: clear beats a valid request
    cyc();
    req_valid = 2'b01; req_write = 2'b00; req_addr = 2'b01; clear_req = 1'b1;
    #1;
    chk("t4_rdy_clr", 32'(req_ready), 0);
    chk("t4_rsp3", {22'd0, rsp_valid, rsp_rdata}, 32'h2A5);
    cyc();
    #1;
    chk("t4_busy0", 32'(clear_busy), 1);
    chk("t4_rdy_c0", 32'(req_ready), 0);
    chk("t4_we_c0", 32'(rf_write_enable), 0);
    chk("t4_rsp_c0", 32'(rsp_valid), 0);
    cyc();
    clear_req = 1'b0;
    #1;
    chk("t4_busy1", 32'(clear_busy), 1);
    chk("t4_rdy_c1", 32'(req_ready), 0);
    chk("t4_w0", {23'd0, rf_write_enable, rf_write_register, rf_write_data}, 32'h200);
    cyc();
    chk("t4_busy2", 32'(clear_busy), 0);
    chk("t4_rdy_after", 32'(req_ready), 32'h1);
    chk("t4_w1", {23'd0, rf_write_enable, rf_write_register, rf_write_data}, 32'h300);
    // test 5: two writes to addr0 then read, last wins
    cyc();
    chk("t4_rsp_cleared", {22'd0, rsp_valid, rsp_rdata}, 32'h100);
    req_write = 2'b01; req_addr = 2'b00; req_wdata = 16'h0011;
    cyc();
    req_wdata = 16'h0022;
    cyc();
    req_write = 2'b00;
    #1;
    chk("t5_wdata", 32'(rf_write_data), 32'h22);
    chk("t5_rdy", 32'(req_ready), 32'h1);
    cyc();
    idle();
    #1 chk("t5_rsp", {22'd0, rsp_valid, rsp_rdata}, 32'h122);
    // test 6: rr=1, req1 write and req0 read same address together
    cyc();
    req_valid = 2'b11; req_write = 2'b10; req_addr = 2'b00; req_wdata = 16'h3C00;
    #1 chk("t6_rdy1", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b01; req_write = 2'b00;
    #1;
    chk("t6_rdy0", 32'(req_ready), 32'h1);
    chk("t6_rsp_w", {22'd0, rsp_valid, rsp_rdata}, 32'h200);
    chk("t6_w", {23'd0, rf_write_enable, rf_write_register, rf_write_data}, 32'h23C);
    cyc();
    idle();
    #1 chk("t6_rsp_r", {22'd0, rsp_valid, rsp_rdata}, 32'h13C);
    cyc();
    chk("t6_quiet", {22'd0, rsp_valid, rsp_rdata}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
